// File: rtl/autoconfig_z2.sv
// Zorro II AutoConfig controller for the expansion fast RAM.
// It serves the configuration nibbles in the $E80000 window and accepts the
// base-address write or the shut-up command. Once configured it drives the RAM
// decoder controls and the CFGOUT_n daisy chain.
module autoconfig_z2 #(
  parameter logic [15:0] MANUFACTURER = 16'h0A1C,
  parameter logic [7:0]  PRODUCT      = 8'h01,
  parameter logic [31:0] SERIAL       = 32'h0000_0001
) (
  input  logic         CLKCPU,
  input  logic         RESET_n,
  input  logic [23:1]  A,
  input  logic         RW_n,
  input  logic         AS_n,
  input  logic         UDS_n,
  input  logic         JP6,
  input  logic         CFGIN_n,
  input  logic [15:12] D_IN,
  output logic [15:12] D_OUT,
  output logic         D_OE,
  output logic         DTACK_AC_n,
  output logic [7:5]   BASE_RAM,
  output logic         RAM_CONFIGURED_n,
  output logic         CFGOUT_n
);

  typedef enum logic [1:0] {StUnconf, StConfigured, StShutup} state_e;

  state_e      state_q, state_d;
  logic [2:0]  base_q, base_d;
  logic [3:0]  low_nibble_q, low_nibble_d;
  logic        done_q, done_d;
  logic        dtack_n_q, dtack_n_d;
  logic [3:0]  dout_q, rdata;
  logic [5:0]  offset;
  logic        ac_hit;
  logic        write_fire;
  logic        unused_sig;

  assign offset     = A[6:1];
  assign ac_hit     = !AS_n && !CFGIN_n && (A[23:16] == 8'hE8) && (state_q == StUnconf);
  // done_q blocks a held write from being committed again on later edges.
  assign write_fire = ac_hit && !RW_n && !UDS_n && !done_q;

  // Only A[23:16] and A[6:1] decode. The low address nibble is kept for
  // completeness, but Zorro II RAM does not use it.
  assign unused_sig = ^{A[15:7], low_nibble_q};

  // Configuration ROM contents indexed by the word offset A[6:1].
  always_comb begin
    rdata = 4'hF;
    case (offset)
      6'h00: rdata = 4'hE;                    // Zorro II, free-list link, no ROM
      6'h01: rdata = JP6 ? 4'h0 : 4'h7;       // 8 MB / 4 MB
      6'h02: rdata = ~PRODUCT[7:4];
      6'h03: rdata = ~PRODUCT[3:0];
      6'h08: rdata = ~MANUFACTURER[15:12];
      6'h09: rdata = ~MANUFACTURER[11:8];
      6'h0A: rdata = ~MANUFACTURER[7:4];
      6'h0B: rdata = ~MANUFACTURER[3:0];
      6'h0C: rdata = ~SERIAL[31:28];
      6'h0D: rdata = ~SERIAL[27:24];
      6'h0E: rdata = ~SERIAL[23:20];
      6'h0F: rdata = ~SERIAL[19:16];
      6'h10: rdata = ~SERIAL[15:12];
      6'h11: rdata = ~SERIAL[11:8];
      6'h12: rdata = ~SERIAL[7:4];
      6'h13: rdata = ~SERIAL[3:0];
      6'h20: rdata = 4'h0;
      6'h21: rdata = 4'h0;
      default: rdata = 4'hF;
    endcase
  end

  // Next state: commit writes, track the per-cycle done flag and the acknowledge.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    low_nibble_d = low_nibble_q;
    done_d       = done_q;
    dtack_n_d    = dtack_n_q;

    if (write_fire) begin
      done_d = 1'b1;
      case (offset)
        6'h25: low_nibble_d = D_IN;
        6'h24: begin
          base_d  = D_IN[15:13];
          state_d = StConfigured;
        end
        6'h26: state_d = StShutup;
        default: ;
      endcase
    end
    if (AS_n) begin
      done_d = 1'b0;
    end

    // The commit makes ac_hit false. done_q keeps DTACK asserted for that cycle.
    if (AS_n) begin
      dtack_n_d = 1'b1;
    end else if (ac_hit || done_q) begin
      dtack_n_d = 1'b0;
    end
  end

  // State registers, reset asynchronously so DTACK negates at once.
  always_ff @(posedge CLKCPU or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q      <= StUnconf;
      base_q       <= 3'b000;
      low_nibble_q <= 4'h0;
      done_q       <= 1'b0;
      dtack_n_q    <= 1'b1;
      dout_q       <= 4'hF;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      low_nibble_q <= low_nibble_d;
      done_q       <= done_d;
      dtack_n_q    <= dtack_n_d;
      dout_q       <= rdata;
    end
  end

  assign D_OUT            = dout_q;
  assign D_OE             = ac_hit && RW_n && !UDS_n;
  assign DTACK_AC_n       = dtack_n_q;
  assign BASE_RAM         = base_q;
  assign RAM_CONFIGURED_n = (state_q != StConfigured);
  assign CFGOUT_n         = !((state_q == StConfigured) || (state_q == StShutup));

endmodule

// File: tb/tb_autoconfig_z2.sv
// Directed bench for autoconfig_z2: ROM reads, the configure and shut-up
// commands, daisy-chain gating and a reset during a bus cycle.
module tb_autoconfig_z2;

  logic        clk;
  logic        rst_n;
  logic [23:1] a;
  logic        rw_n;
  logic        as_n;
  logic        uds_n;
  logic        jp6;
  logic        cfgin_n;
  logic [3:0]  d_in;
  logic [3:0]  d_out;
  logic        d_oe;
  logic        dtack_n;
  logic [2:0]  base_ram;
  logic        ram_cfg_n;
  logic        cfgout_n;

  int n_checks;
  int n_errors;

  autoconfig_z2 dut (
    .CLKCPU           (clk),
    .RESET_n          (rst_n),
    .A                (a),
    .RW_n             (rw_n),
    .AS_n             (as_n),
    .UDS_n            (uds_n),
    .JP6              (jp6),
    .CFGIN_n          (cfgin_n),
    .D_IN             (d_in),
    .D_OUT            (d_out),
    .D_OE             (d_oe),
    .DTACK_AC_n       (dtack_n),
    .BASE_RAM         (base_ram),
    .RAM_CONFIGURED_n (ram_cfg_n),
    .CFGOUT_n         (cfgout_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a cycle at the falling edge, check D_OE, then step past the next rising edge.
  task automatic start_cycle(input logic [7:0] off, input logic rd, input logic [3:0] data,
                             input logic exp_oe);
    @(negedge clk);
    a        = 23'h0;
    a[23:16] = 8'hE8;
    a[7:1]   = off[7:1];
    rw_n     = rd;
    d_in     = data;
    as_n     = 1'b0;
    uds_n    = 1'b0;
    #1;
    check_eq("d_oe", {31'h0, d_oe}, {31'h0, exp_oe});
    @(posedge clk);
    #1;
  endtask

  task automatic end_cycle();
    @(negedge clk);
    as_n  = 1'b1;
    uds_n = 1'b1;
    rw_n  = 1'b1;
    @(posedge clk);
    #1;
    check_eq("dtack_release", {31'h0, dtack_n}, 32'h1);
  endtask

  task automatic do_read(input logic [7:0] off, input logic [3:0] exp);
    start_cycle(off, 1'b1, 4'h0, 1'b1);
    check_eq($sformatf("rd_%02h", off), {28'h0, d_out}, {28'h0, exp});
    check_eq($sformatf("ack_%02h", off), {31'h0, dtack_n}, 32'h0);
    end_cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    a        = 23'h0;
    rw_n     = 1'b1;
    as_n     = 1'b1;
    uds_n    = 1'b1;
    jp6      = 1'b1;
    cfgin_n  = 1'b0;
    d_in     = 4'h0;
    #12;
    check_eq("rst_dtack", {31'h0, dtack_n}, 32'h1);
    check_eq("rst_dout", {28'h0, d_out}, 32'hF);
    check_eq("rst_ramcfg", {31'h0, ram_cfg_n}, 32'h1);
    check_eq("rst_cfgout", {31'h0, cfgout_n}, 32'h1);
    check_eq("rst_base", {29'h0, base_ram}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ROM reads
    do_read(8'h00, 4'hE);
    do_read(8'h02, 4'h0);
    jp6 = 1'b0;
    do_read(8'h02, 4'h7);
    jp6 = 1'b1;
    do_read(8'h04, 4'hF);
    do_read(8'h06, 4'hE);
    do_read(8'h0A, 4'hF);
    do_read(8'h10, 4'hF);
    do_read(8'h12, 4'h5);
    do_read(8'h14, 4'hE);
    do_read(8'h16, 4'h3);
    do_read(8'h18, 4'hF);
    do_read(8'h26, 4'hE);
    do_read(8'h30, 4'hF);
    do_read(8'h40, 4'h0);
    do_read(8'h42, 4'h0);

    // Low-nibble write is stored only; the board stays unconfigured.
    start_cycle(8'h4A, 1'b0, 4'h0, 1'b0);
    check_eq("wr4a_ack", {31'h0, dtack_n}, 32'h0);
    check_eq("wr4a_ramcfg", {31'h0, ram_cfg_n}, 32'h1);
    end_cycle();

    // Base write: outputs change on the commit edge and DTACK holds through the cycle.
    start_cycle(8'h48, 1'b0, 4'h2, 1'b0);
    check_eq("wr48_base", {29'h0, base_ram}, 32'h1);
    check_eq("wr48_ramcfg", {31'h0, ram_cfg_n}, 32'h0);
    check_eq("wr48_cfgout", {31'h0, cfgout_n}, 32'h0);
    check_eq("wr48_ack", {31'h0, dtack_n}, 32'h0);
    @(posedge clk);
    #1;
    check_eq("wr48_ack_hold", {31'h0, dtack_n}, 32'h0);
    end_cycle();

    // After configuration the window is silent.
    start_cycle(8'h00, 1'b1, 4'h0, 1'b0);
    check_eq("post_cfg_ack", {31'h0, dtack_n}, 32'h1);
    end_cycle();
    start_cycle(8'h48, 1'b0, 4'hE, 1'b0);
    check_eq("second_wr_ack", {31'h0, dtack_n}, 32'h1);
    check_eq("second_wr_base", {29'h0, base_ram}, 32'h1);
    end_cycle();

    // Shut-up command.
    do_reset();
    start_cycle(8'h4C, 1'b0, 4'h6, 1'b0);
    check_eq("wr4c_cfgout", {31'h0, cfgout_n}, 32'h0);
    check_eq("wr4c_ramcfg", {31'h0, ram_cfg_n}, 32'h1);
    check_eq("wr4c_base", {29'h0, base_ram}, 32'h0);
    check_eq("wr4c_ack", {31'h0, dtack_n}, 32'h0);
    end_cycle();

    // Daisy chain closed: no response.
    do_reset();
    cfgin_n = 1'b1;
    start_cycle(8'h00, 1'b1, 4'h0, 1'b0);
    check_eq("cfgin_ack", {31'h0, dtack_n}, 32'h1);
    end_cycle();
    cfgin_n = 1'b0;

    // Reset during a held read cycle.
    start_cycle(8'h00, 1'b1, 4'h0, 1'b1);
    check_eq("mid_ack", {31'h0, dtack_n}, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_dtack", {31'h0, dtack_n}, 32'h1);
    check_eq("mid_rst_dout", {28'h0, d_out}, 32'hF);
    end_cycle();
    @(negedge clk);
    rst_n = 1'b1;
    do_read(8'h00, 4'hE);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
